// File: rtl/tff_ctrl_pkg.sv
// tff_ctrl_pkg: shared FSM state encoding and default counter width for tff_counter_ctrl.
package tff_ctrl_pkg;
    localparam int TFF_WIDTH_DEF = 4;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_e;
endpackage

// File: rtl/tff_cell.sv
// tff_cell: single T flip-flop with synchronous active-low reset; toggles when t_i is high.
module tff_cell (
    input  logic clock,
    input  logic reset,
    input  logic t_i,
    output logic q_o
);
    logic q_q;
    always_ff @(posedge clock) begin
        if (!reset) q_q <= 1'b0;
        else        q_q <= q_q ^ t_i;
    end
    assign q_o = q_q;
endmodule

// File: rtl/tff_counter_ctrl.sv
// tff_counter_ctrl: modulo up/down counter built from T flip-flop cells under an IDLE/RUN/PAUSE/DONE FSM.
// Define TFF_CTRL_ONESHOT_EN to stop in DONE on the first terminal count instead of wrapping.
module tff_counter_ctrl
    import tff_ctrl_pkg::*;
#(
    parameter int WIDTH = TFF_WIDTH_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             up_dn,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_mod,
    output logic             cfg_ready,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] mod_q, mod_d, last, step, count_d, t;
    logic             tc_q, xfer, run_step, wrap;

    assign cfg_ready = (state_q == IDLE) || (state_q == DONE);
    assign xfer      = cfg_valid && cfg_ready;
    // A latched modulus of 0 underflows to all-ones, giving the full 2^WIDTH range.
    assign last      = mod_q - 1'b1;
    assign run_step  = (state_q == RUN) && !stop;
    assign wrap      = run_step && (up_dn ? (count == last) : (count == '0));
    assign step      = up_dn ? ((count == last) ? '0 : count + 1'b1)
                             : ((count == '0) ? last : count - 1'b1);
    assign count_d   = xfer ? '0 : run_step ? step : count;
    assign t         = count ^ count_d;
    assign mod_d     = xfer ? cfg_mod : mod_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (start && !stop) ? RUN : IDLE;
`ifdef TFF_CTRL_ONESHOT_EN
            RUN:     state_d = stop ? PAUSE : wrap ? DONE : RUN;
`else
            RUN:     state_d = stop ? PAUSE : RUN;
`endif
            PAUSE:   state_d = stop ? IDLE : start ? RUN : PAUSE;
            DONE:    state_d = (start && !stop) ? RUN : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            mod_q   <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            mod_q   <= mod_d;
            tc_q    <= wrap;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .clock (clock),
            .reset (reset),
            .t_i   (t[i]),
            .q_o   (count[i])
        );
    end

    assign tc   = tc_q;
    assign busy = (state_q == RUN) || (state_q == PAUSE);
`ifdef TFF_CTRL_ONESHOT_EN
    assign done = (state_q == DONE);
`else
    assign done = 1'b0;
`endif
endmodule

// File: doc/tff_counter_ctrl.md
TFF_COUNTER_CTRL -- requirements
Module: tff_counter_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the number of T flip-flop cells (count width).
REQ-002 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have port start, input, 1, run/resume request.
REQ-005 SHALL have port stop, input, 1, pause/abort request.
REQ-006 SHALL have port up_dn, input, 1, direction: 1 counts up, 0 counts down.
REQ-007 SHALL have port cfg_valid, input, 1, modulus-load request.
REQ-008 SHALL have port cfg_mod, input, WIDTH, modulus value.
REQ-009 SHALL have port cfg_ready, output, 1, modulus-load acceptance.
REQ-010 SHALL have port count, output, WIDTH, the Q vector of the cell array.
REQ-011 SHALL have port tc, output, 1, terminal-count pulse.
REQ-012 SHALL have ports busy and done, output, 1 each: status flags.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, PAUSE, DONE.
REQ-014 Transitions SHALL be: IDLE+start -> RUN; RUN+stop -> PAUSE; PAUSE+start -> RUN; PAUSE+stop -> IDLE; DONE+start -> RUN; stop wins when start and stop are both high.
REQ-015 count SHALL advance only in RUN, one step per cycle, starting on the first edge after entering RUN.
REQ-016 SHALL drive each cell's T input with T = count XOR next_count; it SHALL NOT write count directly.
REQ-017 Up count: next = 0 when count == mod-1, else count+1.
REQ-018 Down count: next = mod-1 when count == 0, else count-1.
REQ-019 up_dn SHALL be sampled every RUN cycle; a direction change takes effect on that step.
REQ-020 Latched mod of 0 SHALL mean 2^WIDTH (full-range wrap).
REQ-021 With mod 1, count SHALL stay 0, and tc SHALL pulse on every RUN cycle.
REQ-022 tc SHALL be registered and high for exactly one cycle, coincident with count showing the wrapped value (0 up, mod-1 down).
REQ-023 cfg_ready SHALL be combinationally high in IDLE and DONE only.
REQ-024 A transfer SHALL occur when cfg_valid && cfg_ready; it latches cfg_mod and clears count to 0 on the same edge.
REQ-025 If start and a transfer coincide, the transfer SHALL complete and the FSM enter RUN using the new mod.
REQ-026 busy SHALL be 1 in RUN and PAUSE, else 0.
REQ-027 In PAUSE and IDLE, count SHALL hold (all T = 0).

Reset
REQ-028 While reset == 0 at a clock edge: state = IDLE, count = 0, latched mod = 0, tc = 0, busy = 0, done = 0, cfg_ready = 1.
REQ-029 Reset asserted mid-RUN SHALL abort on that edge with no tc pulse, and with no need to complete the in-progress count.

Configuration
REQ-030 Macro TFF_CTRL_ONESHOT_EN, when defined, SHALL move the FSM RUN -> DONE on the edge that produces tc, where done = 1 and count holds the wrapped value.
REQ-031 Without TFF_CTRL_ONESHOT_EN, the DONE state SHALL be unreachable, RUN SHALL wrap continuously, and done SHALL be tied 0.

Structure
REQ-032 Package tff_ctrl_pkg SHALL hold the FSM state enum typedef and the WIDTH default constant.
REQ-033 The cell array SHALL be WIDTH instances of sub-module tff_cell (T, clock, synchronous active-low reset, Q; toggles when T = 1, holds when T = 0).

Verification
REQ-034 Reset check: reset = 0 for 2 cycles, then release -> count = 0, busy = 0, tc = 0, cfg_ready = 1.
REQ-035 Up wrap: load mod = 5, start, up_dn = 1 -> count 1,2,3,4,0; tc high only on the cycle count = 0; repeats every 5 cycles.
REQ-036 Down wrap: mod = 5, up_dn = 0 -> count 4,3,2,1,0,4; tc on the cycle count = 4.
REQ-037 Pause/resume: stop at count = 3 -> count holds 3 and busy = 1 in PAUSE; start -> next count = 4; start + stop together -> PAUSE.
REQ-038 Boundaries: mod = 0 -> counts 0..15 then wraps; mod = 1 -> count stays 0 and tc = 1 every RUN cycle; cfg_valid during RUN -> cfg_ready = 0 and mod unchanged.
REQ-039 With TFF_CTRL_ONESHOT_EN, mod = 3, start -> count 1,2,0, then done = 1 and count holds 0; assert reset mid-RUN -> next cycle all outputs at reset values.
